i2c_cfg_sequencer: RTL
======================

# i2c_cfg_sequencer

Parametrised sensor register-configuration sequencer. Walks an external configuration table one entry per step and drives a single-transaction I2C master through a request/done handshake. Entry types: write, read-and-verify, timed delay, end marker. Bounded retry on NACK; completion and error status reported to the camera-init controller. Sits between the per-sensor config table (MT9V034 and successors) and the I2C bit-level master.

## Interface
- ADDR_W, 8: sensor register-address width.
- DATA_W, 16: register data width; also the delay-count width.
- IDX_W, 8: table index width; max table depth 2^IDX_W.
- RETRY_MAX, 3: re-issues allowed per entry after NACK (0 = no retry).

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sequence; sampled only in IDLE.
- lut_size  in  IDX_W  number of valid table entries.
- lut_index  out  IDX_W  current table index (registered).
- lut_data  in  2+ADDR_W+DATA_W  {op[1:0], addr, data}; combinational function of lut_index, valid the cycle after lut_index changes.
- i2c_req  out  1  one-cycle transaction request.
- i2c_rw  out  1  0 write, 1 read; valid with i2c_req.
- i2c_addr  out  ADDR_W  register address; valid with i2c_req.
- i2c_wdata  out  DATA_W  write data; valid with i2c_req.
- i2c_done  in  1  one-cycle pulse; transaction finished.
- i2c_nack  in  1  qualified by i2c_done; slave NACK.
- i2c_rdata  in  DATA_W  qualified by i2c_done; read result.
- busy  out  1  sequence in progress.
- cfg_done  out  1  sticky; sequence finished.
- cfg_err  out  1  sticky; at least one error.
- err_code  out  2  01 NACK abort, 10 read mismatch; first error only.
- err_index  out  IDX_W  lut_index of the first error.

## Operation
- Op encoding: 00 WRITE, 01 READ_CHECK (expected value = data), 10 DELAY (data = clock count), 11 END.
- IDLE: busy=0. On start=1: lut_index←0, retry_cnt←0, cfg_done/cfg_err/err_code/err_index←0, go FETCH.
- FETCH: latch lut_data into entry register.
  - lut_index ≥ lut_size, or op=END → DONE.
  - op=DELAY with data=0 → NEXT; nonzero data → DELAY, counter←data.
  - Otherwise → ISSUE.
- ISSUE: i2c_req=1 for exactly this cycle. i2c_rw/addr/wdata come from the entry register and are held stable until the next ISSUE. Go WAIT.
- WAIT: hold until i2c_done. i2c_done in any other state is ignored.
  - nack with retry_cnt<RETRY_MAX: retry_cnt++, go ISSUE.
  - nack with retries exhausted: record error (code 01) if none recorded yet, go DONE (abort).
  - READ_CHECK with rdata≠expected: record error (code 10) if none recorded yet, go NEXT (sequence continues).
  - Otherwise → NEXT.
- DELAY: counter decrements each clock; on the cycle counter=1, go NEXT. Dwell is exactly data cycles.
- NEXT: lut_index++, retry_cnt←0, go FETCH.
- DONE: cfg_done←1, go IDLE. cfg_done/cfg_err remain set until the next accepted start.
- start while busy=1 is ignored.
- lut_index stays at its last value after DONE.
- lut_size=0: DONE immediately, no I2C traffic.
- Only one transaction is outstanding at a time.
- busy=1 in every state except IDLE.

## Timing
- Reset values: lut_index=0, i2c_req=0, i2c_rw=0, i2c_addr=0, i2c_wdata=0, busy=0, cfg_done=0, cfg_err=0, err_code=0, err_index=0, state=IDLE.
- Reset mid-sequence clears everything asynchronously; i2c_req drops at once. The master is responsible for discarding a partial transfer.
- All outputs are registered.
- Start latency: start sampled at edge N → busy=1 and FETCH after N. i2c_req is high for the cycle after edge N+1.
- Per-entry overhead excluding master time:
  - WRITE/READ: i2c_done at edge M → next i2c_req after edge M+2 (NEXT, FETCH, then ISSUE).
  - DELAY: data+2 cycles between adjacent entries' FETCH.
- Retry: nack at edge M → i2c_req re-asserted after edge M, same entry.
- Final-entry completion: i2c_done at edge M → cfg_done=1 after edge M+3; busy=0 after edge M+3.

## Test plan
- Table {W 0x0C=0x0001, W 0x0C=0x0000, W 0x0D=0x0000, END}, lut_size=4, no nack → exactly 3 i2c_req with correct addr/data, cfg_done=1, cfg_err=0, lut_index=3.
- Entry 0 = READ_CHECK 0x00 expect 0x1313; master returns 0x1324 → cfg_err=1, err_code=10, err_index=0; remaining entries still issued; cfg_done=1.
- RETRY_MAX=3; entry 2 NACKs 4 times → 4 requests for entry 2, err_code=01, err_index=2, no further requests, cfg_done=1.
- Entry 1 = DELAY 20 → gap between entry-0 i2c_done and entry-2 i2c_req is 20+4 cycles. DELAY 0 → 4 cycles.
- rst_n low during WAIT of entry 3 → i2c_req=0, busy=0, all status cleared. New start restarts at lut_index=0. start pulsed while busy → ignored, no index reset.
- lut_size=0 with start → cfg_done=1 after 2 cycles, zero i2c_req. i2c_done pulsed in IDLE → no state change.

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - walks a sensor config table and drives a single-transaction I2C master
module i2c_cfg_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 8,
    parameter int RETRY_MAX = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [IDX_W-1:0]           lut_size,
    output logic [IDX_W-1:0]           lut_index,
    input  logic [2+ADDR_W+DATA_W-1:0] lut_data,
    output logic                       i2c_req,
    output logic                       i2c_rw,
    output logic [ADDR_W-1:0]          i2c_addr,
    output logic [DATA_W-1:0]          i2c_wdata,
    input  logic                       i2c_done,
    input  logic                       i2c_nack,
    input  logic [DATA_W-1:0]          i2c_rdata,
    output logic                       busy,
    output logic                       cfg_done,
    output logic                       cfg_err,
    output logic [1:0]                 err_code,
    output logic [IDX_W-1:0]           err_index
);

    localparam int RC_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_DONE
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    lut_index_q;
    logic [RC_W-1:0]     retry_cnt_q;
    logic [DATA_W-1:0]   delay_cnt_q;
    logic                i2c_req_q;
    logic                i2c_rw_q;
    logic [ADDR_W-1:0]   i2c_addr_q;
    logic [DATA_W-1:0]   i2c_wdata_q;
    logic                busy_q;
    logic                cfg_done_q;
    logic                cfg_err_q;
    logic [1:0]          err_code_q;
    logic [IDX_W-1:0]    err_index_q;

    logic [1:0]          lut_op;
    logic [ADDR_W-1:0]   lut_addr;
    logic [DATA_W-1:0]   lut_val;

    assign lut_op   = lut_data[2+ADDR_W+DATA_W-1 -: 2];
    assign lut_addr = lut_data[DATA_W +: ADDR_W];
    assign lut_val  = lut_data[DATA_W-1:0];

    // The held i2c_rw/i2c_wdata double as the entry register: for a read
    // the data field is the expected value, compared when the master finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lut_index_q <= '0;
            retry_cnt_q <= '0;
            delay_cnt_q <= '0;
            i2c_req_q   <= 1'b0;
            i2c_rw_q    <= 1'b0;
            i2c_addr_q  <= '0;
            i2c_wdata_q <= '0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_code_q  <= 2'b00;
            err_index_q <= '0;
        end else begin
            i2c_req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        lut_index_q <= '0;
                        retry_cnt_q <= '0;
                        cfg_done_q  <= 1'b0;
                        cfg_err_q   <= 1'b0;
                        err_code_q  <= 2'b00;
                        err_index_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (lut_index_q >= lut_size || lut_op == OP_END) begin
                        state_q <= S_DONE;
                    end else if (lut_op == OP_DELAY) begin
                        delay_cnt_q <= lut_val;
                        state_q     <= (lut_val == '0) ? S_NEXT : S_DELAY;
                    end else begin
                        i2c_req_q   <= 1'b1;
                        i2c_rw_q    <= (lut_op == OP_READ);
                        i2c_addr_q  <= lut_addr;
                        i2c_wdata_q <= lut_val;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (i2c_done) begin
                        if (i2c_nack) begin
                            if (retry_cnt_q < RC_W'(RETRY_MAX)) begin
                                retry_cnt_q <= retry_cnt_q + 1'b1;
                                i2c_req_q   <= 1'b1;
                                state_q     <= S_ISSUE;
                            end else begin
                                cfg_err_q <= 1'b1;
                                if (!cfg_err_q) begin
                                    err_code_q  <= 2'b01;
                                    err_index_q <= lut_index_q;
                                end
                                state_q <= S_DONE;
                            end
                        end else begin
                            if (i2c_rw_q && i2c_rdata != i2c_wdata_q) begin
                                cfg_err_q <= 1'b1;
                                if (!cfg_err_q) begin
                                    err_code_q  <= 2'b10;
                                    err_index_q <= lut_index_q;
                                end
                            end
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_DELAY: begin
                    delay_cnt_q <= delay_cnt_q - 1'b1;
                    if (delay_cnt_q == DATA_W'(1))
                        state_q <= S_NEXT;
                end
                S_NEXT: begin
                    lut_index_q <= lut_index_q + 1'b1;
                    retry_cnt_q <= '0;
                    state_q     <= S_FETCH;
                end
                S_DONE: begin
                    cfg_done_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign lut_index = lut_index_q;
    assign i2c_req   = i2c_req_q;
    assign i2c_rw    = i2c_rw_q;
    assign i2c_addr  = i2c_addr_q;
    assign i2c_wdata = i2c_wdata_q;
    assign busy      = busy_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign err_code  = err_code_q;
    assign err_index = err_index_q;

endmodule
